xsimintf_hex_rx: RTL and testbench



---
 rtl/xsimintf_hex_rx.sv | 128 ++++++++++++
 tb/tb_xsimintf_hex_rx.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/xsimintf_hex_rx.sv
// ASCII hex frame parser: turns "fafafafa\n"-style text frames into
// WIDTH-bit words on a valid/ready output, with overflow and error flags.
module xsimintf_hex_rx #(
    parameter int WIDTH      = 32,
    parameter int MAX_DIGITS = WIDTH / 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_ovf,
    output logic             err,
    output logic [15:0]      frame_cnt
);

    localparam int NW = $clog2(MAX_DIGITS + 2);
    localparam logic [NW-1:0] L_MAX = NW'(MAX_DIGITS);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DIGITS,
        S_EMIT,
        S_SKIP
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_acc;
    logic [NW-1:0]    r_ndig;
    logic [WIDTH-1:0] r_out_data;
    logic             r_out_valid;
    logic             r_out_ovf;
    logic             r_err;
    logic [15:0]      r_frame_cnt;

    logic             w_fire;
    logic             w_hex;
    logic             w_term;
    logic             w_ws;
    logic             w_bad;
    logic [3:0]       w_nib;

    always_comb begin
        w_hex = 1'b0;
        w_nib = 4'd0;
        if (in_data >= 8'h30 && in_data <= 8'h39) begin
            w_hex = 1'b1;
            w_nib = in_data[3:0];
        end else if ((in_data >= 8'h61 && in_data <= 8'h66) ||
                     (in_data >= 8'h41 && in_data <= 8'h46)) begin
            // low nibble of 'a'/'A' is 1, so add 9 to reach 10
            w_hex = 1'b1;
            w_nib = in_data[3:0] + 4'd9;
        end
    end

    assign w_term = (in_data == 8'h0A) || (in_data == 8'h2C);
    assign w_ws   = (in_data == 8'h20) || (in_data == 8'h09) ||
                    (in_data == 8'h0D);
    assign w_bad  = !(w_hex || w_term || w_ws);

    assign in_ready = (r_state != S_EMIT);
    assign w_fire   = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_acc       <= '0;
            r_ndig      <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_out_ovf   <= 1'b0;
            r_err       <= 1'b0;
            r_frame_cnt <= 16'd0;
        end else begin
            r_err <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (w_fire && w_hex) begin
                        r_acc   <= {{(WIDTH-4){1'b0}}, w_nib};
                        r_ndig  <= NW'(1);
                        r_state <= S_DIGITS;
                    end else if (w_fire && w_bad) begin
                        r_err   <= 1'b1;
                        r_state <= S_SKIP;
                    end
                end
                S_DIGITS: begin
                    if (w_fire && w_hex) begin
                        r_acc <= {r_acc[WIDTH-5:0], w_nib};
                        if (r_ndig <= L_MAX)
                            r_ndig <= r_ndig + NW'(1);
                    end else if (w_fire && (w_term || w_ws)) begin
                        r_out_data  <= r_acc;
                        r_out_ovf   <= (r_ndig > L_MAX);
                        r_out_valid <= 1'b1;
                        r_state     <= S_EMIT;
                    end else if (w_fire && w_bad) begin
                        r_err   <= 1'b1;
                        r_state <= S_SKIP;
                    end
                end
                S_EMIT: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_frame_cnt <= r_frame_cnt + 16'd1;
                        r_state     <= S_IDLE;
                    end
                end
                S_SKIP: begin
                    if (w_fire && w_term)
                        r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;
    assign out_ovf   = r_out_ovf;
    assign err       = r_err;
    assign frame_cnt = r_frame_cnt;

endmodule

// File: tb/tb_xsimintf_hex_rx.sv
// Directed bench for xsimintf_hex_rx: table of text frames with
// hand-computed words, plus stall and reset sequences.
module tb_xsimintf_hex_rx;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_ovf;
    logic        err;
    logic [15:0] frame_cnt;

    int checks = 0;
    int errors = 0;

    logic [32:0] words[$];
    int          err_seen = 0;

    always #5 clk = ~clk;

    xsimintf_hex_rx #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ovf   (out_ovf),
        .err       (err),
        .frame_cnt (frame_cnt)
    );

    // a word seen valid&ready here transfers on the following rising edge
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready)
            words.push_back({out_ovf, out_data});
        if (!rst && err)
            err_seen = err_seen + 1;
    end

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        in_data  = b;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            n = n + 1;
            @(negedge clk);
        end
        if (!in_ready)
            check("in_ready_timeout", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++)
            send_byte(s[i]);
    endtask

    task automatic drain();
        int n = 0;
        while (out_valid && n < 50) begin
            n = n + 1;
            @(posedge clk);
            #1;
        end
        if (out_valid)
            check("drain_timeout", 64'(out_valid), 64'd0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    typedef struct {
        string       txt;
        int          nw;
        logic [31:0] w0;
        logic        o0;
        logic [31:0] w1;
        logic        o1;
        int          nerr;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int base;
        int ebase;
        int exp_cnt;

        vecs[0] = '{"fafafafa\n",   1, 32'hFAFAFAFA, 1'b0, 32'h0, 1'b0, 0};
        vecs[1] = '{"  1A,b\n",     2, 32'h0000001A, 1'b0, 32'hB, 1'b0, 0};
        vecs[2] = '{"123456789\n",  1, 32'h23456789, 1'b1, 32'h0, 1'b0, 0};
        vecs[3] = '{"12g4\n5\n",    1, 32'h00000005, 1'b0, 32'h0, 1'b0, 1};
        vecs[4] = '{"FaFa\t0\r\n",  2, 32'h0000FAFA, 1'b0, 32'h0, 1'b0, 0};
        vecs[5] = '{"\n,\n",        0, 32'h0,        1'b0, 32'h0, 1'b0, 0};
        vecs[6] = '{"x1\n7\n",      1, 32'h00000007, 1'b0, 32'h0, 1'b0, 1};
        vecs[7] = '{"zz,q\n3\n",    1, 32'h00000003, 1'b0, 32'h0, 1'b0, 2};

        in_data   = 8'h00;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        do_reset();

        check("rst_in_ready",  64'(in_ready),  64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data",  64'(out_data),  64'd0);
        check("rst_out_ovf",   64'(out_ovf),   64'd0);
        check("rst_err",       64'(err),       64'd0);
        check("rst_frame_cnt", 64'(frame_cnt), 64'd0);

        exp_cnt = 0;
        for (int v = 0; v < 8; v++) begin
            base  = words.size();
            ebase = err_seen;
            out_ready = 1'b1;
            send_str(vecs[v].txt);
            drain();
            exp_cnt = exp_cnt + vecs[v].nw;
            check($sformatf("v%0d_nwords", v),
                  64'(words.size() - base), 64'(vecs[v].nw));
            if (vecs[v].nw > 0 && words.size() > base) begin
                check($sformatf("v%0d_w0", v),
                      64'(words[base][31:0]), 64'(vecs[v].w0));
                check($sformatf("v%0d_o0", v),
                      64'(words[base][32]), 64'(vecs[v].o0));
            end
            if (vecs[v].nw > 1 && words.size() > base + 1) begin
                check($sformatf("v%0d_w1", v),
                      64'(words[base+1][31:0]), 64'(vecs[v].w1));
                check($sformatf("v%0d_o1", v),
                      64'(words[base+1][32]), 64'(vecs[v].o1));
            end
            check($sformatf("v%0d_err", v),
                  64'(err_seen - ebase), 64'(vecs[v].nerr));
            check($sformatf("v%0d_cnt", v),
                  64'(frame_cnt), 64'(exp_cnt));
        end

        // latency and backpressure: "7\n8\n" with consumer stalled
        do_reset();
        base  = words.size();
        ebase = err_seen;
        out_ready = 1'b0;
        send_byte("7");
        check("lat_before_term", 64'(out_valid), 64'd0);
        send_byte("\n");
        check("lat_valid_next", 64'(out_valid), 64'd1);
        check("lat_data", 64'(out_data), 64'h7);
        in_data  = "8";
        in_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check($sformatf("stall%0d_in_ready", c), 64'(in_ready), 64'd0);
            check($sformatf("stall%0d_valid", c), 64'(out_valid), 64'd1);
            check($sformatf("stall%0d_data", c), 64'(out_data), 64'h7);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send_byte("8");
        send_byte("\n");
        drain();
        check("stall_nwords", 64'(words.size() - base), 64'd2);
        if (words.size() >= base + 2) begin
            check("stall_w0", 64'(words[base][31:0]), 64'h7);
            check("stall_w1", 64'(words[base+1][31:0]), 64'h8);
        end
        check("stall_cnt", 64'(frame_cnt), 64'd2);
        check("stall_err", 64'(err_seen - ebase), 64'd0);

        // reset mid-frame abandons "ab"
        do_reset();
        base  = words.size();
        ebase = err_seen;
        send_str("ab");
        do_reset();
        check("midrst_cnt0", 64'(frame_cnt), 64'd0);
        send_str("c\n");
        drain();
        check("midrst_nwords", 64'(words.size() - base), 64'd1);
        if (words.size() > base)
            check("midrst_w0", 64'(words[base][31:0]), 64'hC);
        check("midrst_cnt", 64'(frame_cnt), 64'd1);
        check("midrst_err", 64'(err_seen - ebase), 64'd0);

        // reset while a word is pending in EMIT
        out_ready = 1'b0;
        send_str("9\n");
        check("emitrst_pending", 64'(out_valid), 64'd1);
        do_reset();
        check("emitrst_valid", 64'(out_valid), 64'd0);
        check("emitrst_in_ready", 64'(in_ready), 64'd1);
        check("emitrst_data", 64'(out_data), 64'd0);
        out_ready = 1'b1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
